nes_pad_reader: RTL and testbench

- Serial front end for the NES gamepad. Drives the controller's latch and clock lines and shifts in the 8 button bits.
- Presents the decoded button byte, plus a status/ack handshake, to the nesip AXI4-Lite register bank directly downstream.
- Runs in the ACLK domain of the AXI slave. Polls either periodically or on a software trigger.

---
 rtl/nes_pkg.sv | 27 ++
 rtl/nes_sync2.sv | 32 +++
 rtl/nes_pad_reader.sv | 164 ++++++++++++++++
 tb/tb_nes_pad_reader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// nes_pkg: definitions shared between the NES pad serial reader and the nesip
// AXI4-Lite register decode.
//   nes_state_e : reader FSM state encoding
//   BTN_*       : bit position of each button in the captured byte
//   NUM_BUTTONS : number of serial bits shifted in per frame
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_LO = 3'd2,
    CLK_HI = 3'd3,
    DONE   = 3'd4
  } nes_state_e;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage : nes_pkg

// File: rtl/nes_sync2.sv
// nes_sync2: two-flop synchronizer for a single asynchronous input.
//   ACLK      in  clock of the destination domain
//   ARESETN   in  asynchronous active-low reset
//   d         in  asynchronous input
//   q         out synchronized output (RESET_VAL while in reset)
// The pad data line idles high (released), so resetting to 1 keeps the first
// samples after reset from reading as a spurious press.
module nes_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic d,
  output logic q
);

  logic meta_q;

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the two stages into one.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule : nes_sync2

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: serial front end for an NES gamepad, clocked by the AXI
// slave's ACLK. Generates the pad latch/clock strobes, shifts in 8 button bits
// and hands the decoded byte to the nesip register bank.
//   ACLK          in  system clock
//   ARESETN       in  asynchronous active-low reset
//   enable        in  periodic polling enable
//   poll_now      in  single-cycle software poll request
//   nes_data      in  pad serial data, active-low, asynchronous
//   status_ack    in  single-cycle clear of status_new
//   nes_latch     out pad latch strobe
//   nes_clk       out pad shift clock, idles high
//   buttons       out last captured byte, 1 = pressed (bit0..7 A,B,Sel,Start,U,D,L,R)
//   buttons_valid out one-cycle pulse in the cycle buttons takes a new value
//   status_new    out sticky "new frame not yet acknowledged"
//   busy          out frame read in progress
//   frame_count   out completed frames, wraps
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned HALF_CYCLES  = 300,
  parameter int unsigned POLL_CYCLES  = 833333
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        enable,
  input  logic        poll_now,
  input  logic        nes_data,
  input  logic        status_ack,
  output logic        nes_latch,
  output logic        nes_clk,
  output logic [7:0]  buttons,
  output logic        buttons_valid,
  output logic        status_new,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int          PHASE_W   = $clog2(PHASE_MAX);
  localparam int          POLL_W    = $clog2(POLL_CYCLES);

  nes_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_cnt;
  logic               phase_done;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_q;
  logic [POLL_W-1:0]  poll_cnt;
  logic               poll_tick;
  logic               start_req;
  logic               data_sync;
  logic               sample_bit;

  nes_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .d       (nes_data),
    .q       (data_sync)
  );

  // Pad data is active-low; store 1 = pressed.
  assign sample_bit = ~data_sync;

  // ---------------------------------------------------------------------------
  // Poll timer. Ticks on its last count; a tick (or poll_now) outside IDLE is
  // simply not looked at by the FSM, so requests are dropped, never queued.
  // ---------------------------------------------------------------------------
  assign poll_tick = enable && (poll_cnt == POLL_W'(POLL_CYCLES - 1));
  assign start_req = poll_tick || poll_now;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      poll_cnt <= '0;
    end else if (!enable || poll_tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Phase timer end: LATCH runs LATCH_CYCLES, both clock halves HALF_CYCLES.
  assign phase_done = (state_q == LATCH) ? (phase_cnt == PHASE_W'(LATCH_CYCLES - 1))
                                         : (phase_cnt == PHASE_W'(HALF_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_req)  state_d = LATCH;
      LATCH:   if (phase_done) state_d = CLK_LO;
      CLK_LO:  if (phase_done) state_d = (bit_idx == 3'(NUM_BUTTONS - 1)) ? DONE : CLK_HI;
      CLK_HI:  if (phase_done) state_d = CLK_LO;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. DONE returns nes_clk to its idle level, so the pad sees its
  // clock low for exactly HALF_CYCLES on every one of the 8 bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    nes_latch = 1'b0;
    nes_clk   = 1'b1;
    busy      = 1'b1;
    unique case (state_q)
      IDLE:    busy      = 1'b0;
      LATCH:   nes_latch = 1'b1;
      CLK_LO:  nes_clk   = 1'b0;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: phase timer, bit index, shift register and result registers.
  // buttons_valid is registered so it is high in the same cycle the new byte,
  // frame_count and status_new become visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      phase_cnt     <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      status_new    <= 1'b0;
      frame_count   <= '0;
    end else begin
      // Restart the phase timer on every state change; hold it in IDLE.
      if (state_q == IDLE || state_d != state_q) phase_cnt <= '0;
      else                                       phase_cnt <= phase_cnt + 1'b1;

      if (state_q == LATCH)                    bit_idx <= '0;
      else if (state_q == CLK_HI && phase_done) bit_idx <= bit_idx + 1'b1;

      // Sample at the end of the low half, when the pad output has settled
      // and passed through the synchronizer.
      if (state_q == CLK_LO && phase_done) shift_q[bit_idx] <= sample_bit;

      buttons_valid <= (state_q == DONE);
      if (state_q == DONE) begin
        buttons     <= shift_q;
        frame_count <= frame_count + 16'd1;
      end

      // Set has priority over a coincident acknowledge.
      if (state_q == DONE)  status_new <= 1'b1;
      else if (status_ack)  status_new <= 1'b0;
    end
  end

endmodule : nes_pad_reader

// File: tb/tb_nes_pad_reader.sv
// Scoreboard bench for nes_pad_reader with a behavioural NES pad model.
module tb_nes_pad_reader;
  import nes_pkg::*;

  localparam int LATCH     = 6;
  localparam int HALF      = 4;
  localparam int POLL      = 200;
  localparam int FRAME_LEN = LATCH + 15 * HALF + 1;  // 67

  logic        tb_ACLK = 1'b0;
  logic        ARESETN;
  logic        enable;
  logic        poll_now;
  logic        nes_data;
  logic        status_ack;
  logic        nes_latch;
  logic        nes_clk;
  logic [7:0]  buttons;
  logic        buttons_valid;
  logic        status_new;
  logic        busy;
  logic [15:0] frame_count;

  always #5 tb_ACLK = ~tb_ACLK;

  nes_pad_reader #(
    .LATCH_CYCLES (LATCH),
    .HALF_CYCLES  (HALF),
    .POLL_CYCLES  (POLL)
  ) dut (
    .ACLK          (tb_ACLK),
    .ARESETN       (ARESETN),
    .enable        (enable),
    .poll_now      (poll_now),
    .nes_data      (nes_data),
    .status_ack    (status_ack),
    .nes_latch     (nes_latch),
    .nes_clk       (nes_clk),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .status_new    (status_new),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Pad model: 4021-style shift register. Loads while latch is high, shifts on
  // each nes_clk rising edge, serial output active-low.
  // ---------------------------------------------------------------------------
  logic [7:0] pad      = 8'h00;
  logic [7:0] model_sr = 8'h00;
  logic       model_prev_clk = 1'b1;

  always @(posedge tb_ACLK) begin
    if (nes_latch)                        model_sr <= pad;
    else if (nes_clk && !model_prev_clk)  model_sr <= {1'b0, model_sr[7:1]};
    model_prev_clk <= nes_clk;
  end

  assign nes_data = ~model_sr[0];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  btn;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] exp_fc = '0;

  always @(negedge tb_ACLK) begin
    if (ARESETN && buttons_valid) begin
      check("valid_has_expectation", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("buttons",     32'(buttons),     32'(e.btn));
        check("frame_count", 32'(frame_count), 32'(e.fc));
        check("status_new",  32'(status_new),  32'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Waveform monitor: per-frame timing of latch, clock halves and busy, plus
  // the auto-poll period when period_chk is set.
  // ---------------------------------------------------------------------------
  logic period_chk = 1'b0;
  int   cyc = 0, last_start = -1;
  int   busy_len, latch_len, run_len, lo_runs, hi_runs, bad_runs;
  logic run_lvl, prev_busy = 1'b0;

  always @(negedge tb_ACLK) begin
    cyc++;
    if (!ARESETN) begin
      prev_busy = 1'b0;
      busy_len = 0; latch_len = 0; run_len = 0; lo_runs = 0; hi_runs = 0; bad_runs = 0;
    end else begin
      if (busy && !prev_busy) begin
        if (period_chk && last_start >= 0) check("poll_period", 32'(cyc - last_start), 32'(POLL));
        last_start = cyc;
        busy_len = 0; latch_len = 0; run_len = 0; lo_runs = 0; hi_runs = 0; bad_runs = 0;
      end
      if (!period_chk) last_start = -1;
      if (busy) begin
        busy_len++;
        if (nes_latch) begin
          latch_len++;
        end else begin
          if (run_len > 0 && nes_clk != run_lvl) begin
            if (run_lvl) hi_runs++; else lo_runs++;
            if (run_len != HALF) bad_runs++;
            run_len = 0;
          end
          run_lvl = nes_clk;
          run_len++;
        end
      end
      if (prev_busy && !busy) begin
        check("busy_len",       32'(busy_len),  32'(FRAME_LEN));
        check("latch_len",      32'(latch_len), 32'(LATCH));
        check("clk_low_runs",   32'(lo_runs),   32'd8);
        check("clk_rise_count", 32'(hi_runs),   32'd7);
        check("clk_half_len",   32'(bad_runs),  32'd0);
        check("idle_nes_clk",   32'(nes_clk),   32'd1);
        check("idle_nes_latch", 32'(nes_latch), 32'd0);
      end
      prev_busy = busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic poll(input logic push, input logic [7:0] btn);
    poll_now = 1'b1;
    if (push) begin
      exp_t e;
      exp_fc++;
      e.btn = btn;
      e.fc  = exp_fc;
      sb_q.push_back(e);
    end
    @(negedge tb_ACLK);
    poll_now = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] btn);
    exp_t e;
    exp_fc++;
    e.btn = btn;
    e.fc  = exp_fc;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge tb_ACLK);
      n++;
    end
    @(negedge tb_ACLK);
    check("drain_scoreboard", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic ack_pulse();
    status_ack = 1'b1;
    @(negedge tb_ACLK);
    status_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nes_latch"},     32'(nes_latch),     32'd0);
    check({tag, "_nes_clk"},       32'(nes_clk),       32'd1);
    check({tag, "_buttons"},       32'(buttons),       32'd0);
    check({tag, "_buttons_valid"}, 32'(buttons_valid), 32'd0);
    check({tag, "_status_new"},    32'(status_new),    32'd0);
    check({tag, "_busy"},          32'(busy),          32'd0);
    check({tag, "_frame_count"},   32'(frame_count),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    enable     = 1'b0;
    poll_now   = 1'b0;
    status_ack = 1'b0;
    ARESETN    = 1'b1;
    #2 ARESETN = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    check_reset_outputs("reset");
    ARESETN = 1'b1;
    @(negedge tb_ACLK);

    // A + Start via poll_now
    pad = 8'h00;
    pad[BTN_A]     = 1'b1;
    pad[BTN_START] = 1'b1;
    poll(1'b1, 8'h09);
    check("busy_after_poll", 32'(busy), 32'd1);
    drain(FRAME_LEN + 10);
    check("buttons_hold", 32'(buttons), 32'h09);

    ack_pulse();
    check("ack_clears", 32'(status_new), 32'd0);

    // Periodic polling, nothing pressed, then Right + Up
    pad        = 8'h00;
    period_chk = 1'b1;
    enable     = 1'b1;
    repeat (3) expect_frame(8'h00);
    drain(3 * POLL + 100);
    pad = 8'h90;
    repeat (2) expect_frame(8'h90);
    drain(2 * POLL + 100);
    enable     = 1'b0;
    period_chk = 1'b0;

    // enable dropped mid-frame: that frame still completes
    repeat (10) @(negedge tb_ACLK);
    enable = 1'b1;
    n = 0;
    while (!busy && n < POLL + 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    check("auto_poll_started", 32'(busy), 32'd1);
    repeat (3) @(negedge tb_ACLK);
    enable = 1'b0;
    expect_frame(8'h90);
    drain(FRAME_LEN + 10);

    // status_ack coincident with DONE: set wins
    ack_pulse();
    check("ack_clears_2", 32'(status_new), 32'd0);
    pad = 8'h55;
    poll(1'b1, 8'h55);
    repeat (FRAME_LEN - 1) @(negedge tb_ACLK);
    check("in_done_busy", 32'(busy), 32'd1);
    status_ack = 1'b1;
    @(negedge tb_ACLK);
    status_ack = 1'b0;
    check("set_wins_over_ack", 32'(status_new), 32'd1);
    drain(10);
    ack_pulse();
    check("later_ack_clears", 32'(status_new), 32'd0);

    // poll_now during LATCH (index 2) and CLK_HI of bit 0 (index 11) ignored
    pad = 8'hA2;
    poll(1'b1, 8'hA2);
    repeat (2) @(negedge tb_ACLK);
    poll(1'b0, 8'h00);
    repeat (8) @(negedge tb_ACLK);
    poll(1'b0, 8'h00);
    drain(FRAME_LEN + 10);
    repeat (100) @(negedge tb_ACLK);
    check("single_frame_count", 32'(frame_count), 32'(exp_fc));
    check("idle_after_drop", 32'(busy), 32'd0);

    // Reset during CLK_HI of bit 3 (index 35)
    pad = 8'h3C;
    poll(1'b0, 8'h00);
    repeat (35) @(negedge tb_ACLK);
    ARESETN = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    exp_fc = '0;
    repeat (2) @(negedge tb_ACLK);
    ARESETN = 1'b1;
    @(negedge tb_ACLK);
    check("post_reset_idle", 32'(busy), 32'd0);
    poll(1'b1, 8'h3C);
    drain(FRAME_LEN + 10);

    repeat (20) @(negedge tb_ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nes_pad_reader
